// File: rtl/snake_dmem_scanner_pkg.sv
// Shared definitions for the snake dmem scanner: FSM encoding, defaults, widths.
package snake_dmem_scanner_pkg;

   localparam int ADDR_W = 12;
   localparam int WORD_W = 32;

   localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 12'd100;
   localparam int DEFAULT_NUM_WORDS = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_COMMIT = 2'd3
   } scan_state_t;

   // Width of a word-slot index; at least one bit even for a single-word frame.
   function automatic int slot_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snake_dmem_scanner_if.sv
// Second read port of dmem as seen by the VGA-side scanner.
interface snake_dmem_scanner_if;

   logic [snake_dmem_scanner_pkg::ADDR_W-1:0] address_dmem_fromVGA;
   logic [snake_dmem_scanner_pkg::WORD_W-1:0] data_fromVGA;
   logic                                      wren_fromVGA;
   logic [snake_dmem_scanner_pkg::WORD_W-1:0] q_dmem_toVGA;

   // The scanner issues addresses and receives read data.
   modport master (
      output address_dmem_fromVGA,
      output data_fromVGA,
      output wren_fromVGA,
      input  q_dmem_toVGA
   );

   // The memory side answers with read data one cycle after the address.
   modport slave (
      input  address_dmem_fromVGA,
      input  data_fromVGA,
      input  wren_fromVGA,
      output q_dmem_toVGA
   );

endinterface

// File: rtl/snake_frame_buffer.sv
// Shadow word bank filled slot by slot, copied to the visible snapshot in one edge.
module snake_frame_buffer
   import snake_dmem_scanner_pkg::*;
#(
   parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
   parameter int IDX_W     = slot_width(DEFAULT_NUM_WORDS)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wr_en_i,
   input  logic [IDX_W-1:0]              wr_slot_i,
   input  logic [WORD_W-1:0]             wr_data_i,
   input  logic                          commit_i,
   output logic [NUM_WORDS*WORD_W-1:0]   snapshot_o
);

   logic [WORD_W-1:0]           shadow_q [NUM_WORDS];
   logic [NUM_WORDS*WORD_W-1:0] snap_q;

   // Shadow slots collect words as they return from dmem during a scan.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (wr_en_i && (int'(wr_slot_i) < NUM_WORDS)) begin
         shadow_q[wr_slot_i] <= wr_data_i;
      end
   end

   // The snapshot only moves on commit so the display never sees a half-updated frame.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         snap_q <= '0;
      end else if (commit_i) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            snap_q[WORD_W*i +: WORD_W] <= shadow_q[i];
         end
      end
   end

   assign snapshot_o = snap_q;

endmodule

// File: rtl/snake_dmem_scanner.sv
// Reads a block of dmem words once per VGA frame and publishes them as one atomic snapshot.
module snake_dmem_scanner
   import snake_dmem_scanner_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int                NUM_WORDS = DEFAULT_NUM_WORDS
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         scan_enable,
   input  logic                         frame_start,
   snake_dmem_scanner_if.master         dmem,
   output logic [NUM_WORDS*WORD_W-1:0]  snake_data,
   output logic                         snake_valid,
   output logic                         busy,
   output logic                         frame_overrun
);

   localparam int IDX_W = slot_width(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   scan_state_t       state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic              valid_q;
   logic              busy_q;
   logic              overrun_q;
   logic              cap_valid_q;
   logic [IDX_W-1:0]  cap_slot_q;
   logic [IDX_W-1:0]  idx_d;

   assign idx_d = idx_q + IDX_ONE;

   // Scan sequencer: walks the word addresses, waits for the last read, then commits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         addr_q  <= BASE_ADDR;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (frame_start && scan_enable) begin
                  state_q <= ST_READ;
                  idx_q   <= '0;
                  addr_q  <= BASE_ADDR;
                  busy_q  <= 1'b1;
               end
            end
            ST_READ: begin
               if (idx_q == LAST_IDX) begin
                  state_q <= ST_DRAIN;
                  idx_q   <= '0;
                  addr_q  <= BASE_ADDR;
               end else begin
                  idx_q  <= idx_d;
                  addr_q <= BASE_ADDR + ADDR_W'(idx_d);
               end
            end
            ST_DRAIN: begin
               state_q <= ST_COMMIT;
            end
            ST_COMMIT: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               idx_q   <= '0;
               addr_q  <= BASE_ADDR;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Remember which slot the in-flight read belongs to, since dmem answers a cycle later.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cap_valid_q <= 1'b0;
         cap_slot_q  <= '0;
      end else begin
         cap_valid_q <= (state_q == ST_READ);
         cap_slot_q  <= idx_q;
      end
   end

   // A vsync arriving mid-scan is dropped but latched so software can see frames were missed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overrun_q <= 1'b0;
      end else if (frame_start && (state_q != ST_IDLE)) begin
         overrun_q <= 1'b1;
      end
   end

   snake_frame_buffer #(
      .NUM_WORDS (NUM_WORDS),
      .IDX_W     (IDX_W)
   ) u_frame_buffer (
      .clock      (clock),
      .reset      (reset),
      .wr_en_i    (cap_valid_q),
      .wr_slot_i  (cap_slot_q),
      .wr_data_i  (dmem.q_dmem_toVGA),
      .commit_i   (state_q == ST_COMMIT),
      .snapshot_o (snake_data)
   );

   assign dmem.address_dmem_fromVGA = addr_q;
   assign dmem.data_fromVGA         = '0;
   assign dmem.wren_fromVGA         = 1'b0;

   assign snake_valid   = valid_q;
   assign busy          = busy_q;
   assign frame_overrun = overrun_q;

endmodule
